// File: rtl/maxpool_scan_ctrl_pkg.sv
// rtl/maxpool_scan_ctrl_pkg.sv - shared types, defaults and output-size helpers for the 3x3 max-pool scanner
//
// Purpose: state encoding, default widths and the OUT_W/OUT_H derivation,
//          which the layer FSM also uses to size the output buffer.
package maxpool_scan_ctrl_pkg;

  localparam int MP_DATA_W = 16;
  localparam int MP_ADDR_W = 12;
  localparam int MP_WIN    = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Number of whole windows along one axis; partial edge windows are dropped.
  function automatic int calc_out_w(input int img_w, input int stride);
    return (img_w - MP_WIN) / stride + 1;
  endfunction

  function automatic int calc_out_h(input int img_h, input int stride);
    return (img_h - MP_WIN) / stride + 1;
  endfunction

endpackage

// File: rtl/maxpool_scan_ctrl_cmp.sv
// rtl/maxpool_scan_ctrl_cmp.sv - combinational 9-input unsigned maximum (3x3 MaxPool comparator)
//
// Purpose: returns the largest of din1..din9; ties return the shared value.
// Ports:
//   din1..din9  in  DATA_W  window pixels (unsigned)
//   dout        out DATA_W  maximum of the nine inputs
module maxpool_scan_ctrl_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic [DATA_W-1:0] din4,
  input  logic [DATA_W-1:0] din5,
  input  logic [DATA_W-1:0] din6,
  input  logic [DATA_W-1:0] din7,
  input  logic [DATA_W-1:0] din8,
  input  logic [DATA_W-1:0] din9,
  output logic [DATA_W-1:0] dout
);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0] w_m12, w_m34, w_m56, w_m78, w_m1234, w_m5678, w_m18;

  // Balanced tree keeps the comparator depth at four levels.
  assign w_m12   = max2(din1, din2);
  assign w_m34   = max2(din3, din4);
  assign w_m56   = max2(din5, din6);
  assign w_m78   = max2(din7, din8);
  assign w_m1234 = max2(w_m12, w_m34);
  assign w_m5678 = max2(w_m56, w_m78);
  assign w_m18   = max2(w_m1234, w_m5678);
  assign dout    = max2(w_m18, din9);

endmodule

// File: rtl/maxpool_scan_ctrl.sv
// rtl/maxpool_scan_ctrl.sv - scans a feature map in SRAM and writes 3x3 window maxima
//
// Purpose: fetches the nine taps of each window (9 reads), drains the last
//          read, then writes the window maximum; 11 cycles per window.
// Ports:
//   clk      in  1       rising-edge clock
//   reset    in  1       asynchronous active-high reset
//   start    in  1       pulse starting a full-map pass (ignored unless idle)
//   busy     out 1       high in FETCH/DRAIN/WRITE
//   done     out 1       one-cycle pulse after the last write
//   rd_en    out 1       input SRAM read strobe
//   rd_addr  out ADDR_W  input pixel address, y*IMG_W + x
//   rd_data  in  DATA_W  read data, valid one cycle after rd_en
//   wr_en    out 1       output write strobe
//   wr_addr  out ADDR_W  output address, oy*OUT_W + ox
//   wr_data  out DATA_W  window maximum
module maxpool_scan_ctrl
  import maxpool_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = MP_DATA_W,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int STRIDE = 3,
  parameter int ADDR_W = MP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int LP_OUT_W = calc_out_w(IMG_W, STRIDE);
  localparam int LP_OUT_H = calc_out_h(IMG_H, STRIDE);

  localparam logic [ADDR_W-1:0] LP_STRIDE_A  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LP_IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LP_OUT_W_A   = ADDR_W'(LP_OUT_W);
  localparam logic [ADDR_W-1:0] LP_OUT_W_M1  = ADDR_W'(LP_OUT_W - 1);
  localparam logic [ADDR_W-1:0] LP_OUT_H_M1  = ADDR_W'(LP_OUT_H - 1);

  generate
    if (IMG_W * IMG_H > (2 ** ADDR_W)) begin : g_bad_addr_w
      $error("maxpool_scan_ctrl: IMG_W*IMG_H exceeds 2**ADDR_W");
    end
    if (STRIDE < 1 || STRIDE > 3) begin : g_bad_stride
      $error("maxpool_scan_ctrl: STRIDE must be 1..3");
    end
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_img
      $error("maxpool_scan_ctrl: map smaller than one window");
    end
  endgenerate

  state_t            r_state;
  logic [ADDR_W-1:0] r_ox, r_oy;
  logic [3:0]        r_k;
  logic [DATA_W-1:0] r_cap [9];
  logic              r_busy, r_done, r_rd_en, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;

  logic              w_last_col, w_last_win;
  logic [ADDR_W-1:0] w_next_ox, w_next_oy;
  logic [DATA_W-1:0] w_max;

  // Address of tap k (row-major inside the window) for window (ox, oy).
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] ox,
                                                 input logic [ADDR_W-1:0] oy,
                                                 input logic [3:0]        k);
    logic [ADDR_W-1:0] kr, kc;
    kr = ADDR_W'(k / 4'd3);
    kc = ADDR_W'(k % 4'd3);
    return (oy * LP_STRIDE_A + kr) * LP_IMG_W_A + ox * LP_STRIDE_A + kc;
  endfunction

  assign w_last_col = (r_ox == LP_OUT_W_M1);
  assign w_last_win = w_last_col && (r_oy == LP_OUT_H_M1);
  assign w_next_ox  = w_last_col ? '0 : r_ox + 1'b1;
  assign w_next_oy  = w_last_col ? r_oy + 1'b1 : r_oy;

  maxpool_scan_ctrl_cmp #(.DATA_W(DATA_W)) u_cmp (
    .din1 (r_cap[0]),
    .din2 (r_cap[1]),
    .din3 (r_cap[2]),
    .din4 (r_cap[3]),
    .din5 (r_cap[4]),
    .din6 (r_cap[5]),
    .din7 (r_cap[6]),
    .din8 (r_cap[7]),
    .din9 (r_cap[8]),
    .dout (w_max)
  );

  // Strobes and addresses are registered one cycle ahead: each transition
  // loads the values the next state must present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ox      <= '0;
      r_oy      <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      for (int i = 0; i < 9; i++) r_cap[i] <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ox      <= '0;
            r_oy      <= '0;
            r_k       <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Data for the previous tap arrives this cycle.
          if (r_k != 4'd0) r_cap[r_k - 4'd1] <= rd_data;
          if (r_k == 4'd8) begin
            r_state <= S_DRAIN;
          end else begin
            r_k       <= r_k + 4'd1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= tap_addr(r_ox, r_oy, r_k + 4'd1);
          end
        end
        S_DRAIN: begin
          r_cap[8]  <= rd_data;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_oy * LP_OUT_W_A + r_ox;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          r_ox <= w_next_ox;
          r_oy <= w_next_oy;
          if (w_last_win) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k       <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= tap_addr(w_next_ox, w_next_oy, 4'd0);
            r_state   <= S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = w_max;

endmodule

// File: tb/tb_maxpool_scan_ctrl.sv
// tb/tb_maxpool_scan_ctrl.sv - self-checking bench for maxpool_scan_ctrl
module tb_maxpool_scan_ctrl;

  localparam int W = 64, H = 64, S = 3, OW = 21, OH = 21, NWIN = OW * OH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, rd_en, wr_en;
  logic [11:0] rd_addr, wr_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] wr_data;

  maxpool_scan_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  bit mon_on = 1'b0;
  int t0 = 0;
  int rd_cnt, done_cnt, done_cyc, first_wr_cyc, both_cnt, x_cnt;
  int wq_addr [$];
  int wq_data [$];
  int rd_en_tr [11];
  int rd_addr_tr [11];

  task automatic clear_mon();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1;
    both_cnt = 0; x_cnt = 0;
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 11; i++) begin rd_en_tr[i] = -1; rd_addr_tr[i] = -1; end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      int rel;
      rel = cyc - t0;
      if (rd_en) rd_cnt++;
      if (rel >= 1 && rel <= 10) begin
        rd_en_tr[rel]   = int'(rd_en);
        rd_addr_tr[rel] = int'(rd_addr);
      end
      if (wr_en) begin
        if (wq_addr.size() == 0) first_wr_cyc = rel;
        if ($isunknown(wr_data)) x_cnt++;
        wq_addr.push_back(int'(wr_addr));
        wq_data.push_back(int'(wr_data));
      end
      if (done) begin done_cnt++; done_cyc = rel; end
      if (rd_en && wr_en) both_cnt++;
    end
  end

  // ---------------- checking ----------------
  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: maximum of the 3x3 window taken straight from the image.
  function automatic int model_max(input int ox, input int oy);
    int m;
    m = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        if (int'(mem[(oy * S + dy) * W + ox * S + dx]) > m)
          m = int'(mem[(oy * S + dy) * W + ox * S + dx]);
    return m;
  endfunction

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, wq_addr.size(), NWIN);
    for (int i = 0; i < NWIN && i < wq_addr.size(); i++) begin
      chk($sformatf("%s_wr_addr[%0d]", tag, i), wq_addr[i], i);
      chk($sformatf("%s_wr_data[%0d]", tag, i), wq_data[i], model_max(i % OW, i / OW));
    end
    chk({tag, "_rd_count"}, rd_cnt, NWIN * 9);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, NWIN * 11 + 1);
    chk({tag, "_rd_wr_overlap"}, both_cnt, 0);
    chk({tag, "_wr_data_x"}, x_cnt, 0);
  endtask

  // restart=1 re-pulses start during busy (cycle 50) and in DONE (cycle 4852)
  task automatic run_pass(input bit restart);
    int n;
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; mon_on = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      @(posedge clk); #1;
      start = restart && ((cyc - t0) == 50 || (cyc - t0) == NWIN * 11 + 1);
      n++;
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (20) @(posedge clk);
    #1 mon_on = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int    img;     // 0 = ramp, 1 = single hot pixel
    int    waddr;
    int    exp;
  } vec_t;

  vec_t vecs [10];

  task automatic apply_vecs(input int img);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].img == img) begin
        if (vecs[i].waddr < wq_data.size())
          chk(vecs[i].name, wq_data[vecs[i].waddr], vecs[i].exp);
        else
          chk({vecs[i].name, "_missing"}, wq_data.size(), vecs[i].waddr + 1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{"ramp_w0_0",   0, 0,   130};
    vecs[1] = '{"ramp_w20_20", 0, 440, 4030};
    vecs[2] = '{"ramp_w1_0",   0, 1,   133};
    vecs[3] = '{"ramp_w20_0",  0, 20,  190};
    vecs[4] = '{"ramp_w0_1",   0, 21,  322};
    vecs[5] = '{"hot_w1_1",    1, 22,  65535};
    vecs[6] = '{"hot_w0_1",    1, 21,  0};
    vecs[7] = '{"hot_w2_1",    1, 23,  0};
    vecs[8] = '{"hot_w1_2",    1, 43,  0};
    vecs[9] = '{"hot_w0_0",    1, 0,   0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0;

    // ramp image with first-window address trace
    load_ramp();
    run_pass(1'b0);
    begin
      int exp_a [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("ramp_rd_en_c%0d", i + 1), rd_en_tr[i + 1], 1);
        chk($sformatf("ramp_rd_addr_c%0d", i + 1), rd_addr_tr[i + 1], exp_a[i]);
      end
      chk("ramp_drain_rd_en", rd_en_tr[10], 0);
    end
    chk("ramp_first_wr_cycle", first_wr_cyc, 11);
    check_writes("ramp");
    apply_vecs(0);

    // constant image, every window ties
    for (int i = 0; i < 4096; i++) mem[i] = 16'h7FFF;
    run_pass(1'b0);
    check_writes("const");
    for (int i = 0; i < wq_data.size(); i++)
      if (wq_data[i] != 32'h7FFF) chk($sformatf("const_val[%0d]", i), wq_data[i], 32'h7FFF);

    // single hot pixel at (4,4)
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[4 * W + 4] = 16'hFFFF;
    run_pass(1'b0);
    check_writes("hot");
    apply_vecs(1);

    // random image
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom_range(0, 65535));
    run_pass(1'b0);
    check_writes("rand");

    // start re-pulsed while busy and while in DONE
    load_ramp();
    run_pass(1'b1);
    check_writes("restart");
    apply_vecs(0);

    // asynchronous reset mid-FETCH of window 5, then a clean restart
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((cyc - t0) < 60) begin @(posedge clk); #1; end
    #2;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rd_en", rd_en, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_en", rd_en, 0);
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_wr_data", wr_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_pass(1'b0);
    chk("post_rst_rd_addr_c1", rd_addr_tr[1], 0);
    chk("post_rst_first_wr_cycle", first_wr_cyc, 11);
    chk("post_rst_first_wr_addr", (wq_addr.size() > 0) ? wq_addr[0] : -1, 0);
    chk("post_rst_first_wr_data", (wq_data.size() > 0) ? wq_data[0] : -1, 130);
    check_writes("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maxpool_scan_ctrl.md
Name: maxpool_scan_ctrl

Overview:
- Sequencer for the team's combinational 3x3 MaxPool comparator (din1..din9 in, dout = maximum out, 16-bit unsigned).
- Scans a feature map held in an external single-port SRAM and fetches the 9 pixels of each 3x3 window into capture registers.
- Drives the comparator from those registers and writes each window maximum to an output buffer.
- Sits between the convolution-result memory and the layer-output memory; started by the top-level layer FSM.

Parameters:
- DATA_W, 16, pixel width (unsigned).
- IMG_W, 64, input map width in pixels.
- IMG_H, 64, input map height in pixels.
- STRIDE, 3, window step in x and y (1..3).
- ADDR_W, 12, input and output address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a full-map pass.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  input SRAM read strobe.
- rd_addr  out  ADDR_W  input pixel address, row-major (y*IMG_W + x).
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  output write strobe.
- wr_addr  out  ADDR_W  output address (oy*OUT_W + ox).
- wr_data  out  DATA_W  window maximum.

Behaviour:
- Derived constants: OUT_W = (IMG_W-3)/STRIDE+1 and OUT_H = (IMG_H-3)/STRIDE+1. With defaults, OUT_W = OUT_H = 21, giving 441 windows.
- Reset (asynchronous, any time): state goes to IDLE; all outputs, window counters ox/oy, tap counter k and capture registers cap0..cap8 are cleared to 0.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: on start=1, clear ox, oy and k, then go to FETCH.
- FETCH (exactly 9 cycles, k = 0..8):
  - rd_en = 1.
  - rd_addr = (oy*STRIDE + k/3)*IMG_W + ox*STRIDE + k%3.
  - The datum returned for tap k-1 is registered into cap[k-1].
  - After k=8, go to DRAIN.
- DRAIN (1 cycle): rd_en = 0; rd_data is registered into cap8; go to WRITE.
- WRITE (1 cycle):
  - wr_en = 1, wr_addr = oy*OUT_W + ox, wr_data = comparator output over cap0..cap8 (din1 = cap0 ... din9 = cap8).
  - Advance ox; on ox = OUT_W-1, wrap ox to 0 and increment oy.
  - If the written window was the last one (ox = OUT_W-1 and oy = OUT_H-1), go to DONE; otherwise reset k and go to FETCH.
- DONE (1 cycle): done = 1, busy = 0, then go to IDLE.
- Timing: 11 cycles per window. With start high in cycle 0:
  - first rd_en in cycle 1;
  - first wr_en in cycle 11;
  - done in cycle 441*11 + 1 = 4852 (defaults).
- busy = 1 in FETCH, DRAIN and WRITE; 0 in IDLE and DONE.
- start while busy or in DONE: ignored, no restart, counters unaffected.
- Equal pixel values: the maximum value is still produced (which tap wins is irrelevant).
- All arithmetic is unsigned. Address products are ADDR_W wide; the parameter check is IMG_W*IMG_H <= 2^ADDR_W (elaboration-time assertion). Edge columns and rows that do not fill a window are skipped (no padding).
- rd_en and wr_en are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, FETCH=1, DRAIN=2, WRITE=3, DONE=4);
  - the DATA_W and ADDR_W defaults;
  - the OUT_W/OUT_H derivation functions, which the layer FSM also uses to size the output buffer.
- One sub-module: the existing MaxPool comparator, instantiated once and fed from cap0..cap8.
- The address generator stays inline (small).

Test Plan:
- Ramp image (pixel = address mod 2^16), start pulse:
  - window (0,0) writes 130 to wr_addr 0;
  - window (20,20) writes 4030 to wr_addr 440;
  - exactly 441 wr_en pulses; done in cycle 4852.
- Constant image of 0x7FFF: all 441 writes carry 0x7FFF (tie handling); no X on wr_data.
- All-zero image except pixel (x=4, y=4) = 0xFFFF: wr_addr 22 gets 0xFFFF; every other address gets 0.
- start re-pulsed in cycles 50 and 4852 (during busy and during DONE): no extra reads; the write sequence is identical to the single-start run; done pulses once.
- Reset asserted asynchronously mid-FETCH of window 5: busy, rd_en and wr_en drop to 0 immediately. A subsequent start restarts at rd_addr 0, with the first write at wr_addr 0 and value 130 on the ramp image.
- Read-address check across the first window: rd_addr sequence is 0, 1, 2, 64, 65, 66, 128, 129, 130 in cycles 1..9, followed by a DRAIN cycle with rd_en = 0.
